ysyx_25040118_regdump: RTL and testbench
========================================

// Module: ysyx_25040118_regdump
// PURPOSE
//  Reader-side companion to the RV32E register file. On request it walks x0..x15
//  through a spare regfile read port and streams one {idx,data} beat per register
//  over a valid/ready interface. Consumers are the sdb, difftest and trap-dump paths.
//  It snoops the regfile write port and reports, per register, whether the value it
//  emitted went stale before the dump finished.
// PARAMETERS
//  NREGS  16  number of architectural registers walked (RV32E)
//  XLEN   32  register data width
//  AW     5   regfile address width
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      dump request; sampled only in IDLE
//  busy       out  1      high from the cycle after start is accepted through DONE
//  raddr      out  AW     to regfile read port; combinational read, data on rdata same cycle
//  rdata      in   XLEN   regfile read data for raddr
//  wen        in   1      snoop: regfile write enable
//  waddr      in   AW     snoop: regfile write address
//  out_valid  out  1      beat valid
//  out_ready  in   1      consumer accepts beat
//  out_idx    out  4      register index of current beat
//  out_data   out  XLEN   register value of current beat
//  out_last   out  1      out_valid && out_idx==NREGS-1
//  done       out  1      one-cycle pulse after last beat handshake
//  dirty      out  NREGS  bit j set: xj written after its value was captured
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, idx=0, all outputs 0, dirty=0.
//  FSM states and transitions:
//   IDLE : raddr=0; start=1 -> READ, idx<=0, dirty<=0. busy=0.
//   READ : raddr=idx; capture out_data<=(idx==0)?0:rdata -> HOLD. Takes 1 cycle.
//   HOLD : out_valid=1; out_idx/out_data stable until handshake (valid&&ready).
//          handshake && idx==NREGS-1 -> DONE; handshake otherwise -> READ, idx<=idx+1.
//          no handshake -> stay in HOLD.
//   DONE : done=1 for exactly 1 cycle -> IDLE. busy is 1 in DONE.
//  Latency and throughput:
//   - First beat is valid 2 cycles after the start cycle.
//   - Minimum 2 cycles per beat.
//   - With out_ready tied high, done rises 33 cycles after start.
//  start is ignored while busy. No queueing; back-to-back start needs IDLE.
//  Read/write collision:
//   - The regfile writes at posedge, so the capture in READ sees the pre-write value.
//   - A same-cycle write to idx is therefore emitted old. It also sets dirty[idx].
//  dirty[j] rules:
//   - Set on wen && waddr==j && j!=0 && j<NREGS && (j<idx, or j==idx in READ/HOLD).
//   - Writes to not-yet-captured regs are not dirty; they appear in their later beat.
//   - Writes to x0 or waddr>=NREGS are ignored.
//   - dirty is held after DONE until the next accepted start.
//   - In DONE and IDLE, dirty updates only on that start (cleared).
//  idx is 4 bits wide and never wraps; the walk terminates at NREGS-1.
// TESTING
//  1. x1..x15=0x100+i, start, out_ready=1 -> 16 beats: idx 0..15, data 0,0x101..0x10F;
//     out_last only on idx15; done in cycle 33; dirty=0.
//  2. out_ready=0 for 5 cycles while idx=3 beat is valid -> idx/data held,
//     no beat lost or duplicated, idx4 follows.
//  3. Write x5=0xDEAD while idx=2 -> beat5 data 0xDEAD, dirty[5]=0.
//     Write x1=0x55 after beat1 -> dirty=0x0002.
//  4. Write x7 in the READ cycle of idx7 -> beat7 shows old value, dirty[7]=1.
//     Writes to x0 and waddr=20 -> dirty unchanged.
//  5. start pulsed while busy -> ignored, single 16-beat dump.
//  6. rst asserted mid-dump at idx7 -> outputs 0 immediately without a clock edge;
//     after release, start -> dump restarts at idx0.

Source files
------------

// File: rtl/ysyx_25040118_regdump_if.sv
`timescale 1ns/1ps
// Beat stream carrying one {idx,data} pair per architectural register.
// master: the dump engine; slave: sdb / difftest / trap-dump consumer.
interface ysyx_25040118_regdump_if #(
   parameter int XLEN = 32,
   parameter int IW   = 4
);
   logic            out_valid;
   logic            out_ready;
   logic [IW-1:0]   out_idx;
   logic [XLEN-1:0] out_data;
   logic            out_last;

   modport master (
      output out_valid,
      output out_idx,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/ysyx_25040118_regdump.sv
`timescale 1ns/1ps
// Register-file dump engine for the RV32E core.
// Walks x0..x(NREGS-1) through a spare combinational read port and emits one
// beat per register. The regfile write port is snooped so each register whose
// emitted value was overwritten before the walk ended is flagged in dirty.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; dirty from the previous dump is held
//  READ  | raddr=idx, capture rdata (x0 forced to zero) into the beat
//  HOLD  | beat valid; wait for handshake, then next reg or finish
//  DONE  | one-cycle done pulse, busy still high
module ysyx_25040118_regdump #(
   parameter int NREGS = 16,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic [AW-1:0]           raddr,
   input  logic [XLEN-1:0]         rdata,
   input  logic                    wen,
   input  logic [AW-1:0]           waddr,
   ysyx_25040118_regdump_if.master ob,
   output logic                    done,
   output logic [NREGS-1:0]        dirty
);
   localparam int            IW       = 4;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [XLEN-1:0]  data_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;
   logic [NREGS-1:0] dirty_q;
   logic [NREGS-1:0] dirty_set;
   logic             hs;

   assign hs = valid_q && ob.out_ready;

   // A snooped write marks a register stale only once its value has been
   // captured: indices below the cursor, or the cursor itself (a write in the
   // READ cycle lands after the capture edge, so the beat carries the old value).
   always_comb begin
      dirty_set = '0;
      if (wen && (waddr != '0) && (waddr < AW'(NREGS)) && (waddr <= AW'(idx)))
         dirty_set[waddr[IW-1:0]] = 1'b1;
   end

   // Dump sequencer: state, cursor, captured beat and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dirty_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  idx     <= '0;
                  dirty_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            READ: begin
               data_q  <= (idx == '0) ? '0 : rdata;
               valid_q <= 1'b1;
               dirty_q <= dirty_q | dirty_set;
               state   <= HOLD;
            end
            HOLD: begin
               dirty_q <= dirty_q | dirty_set;
               if (hs) begin
                  valid_q <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= READ;
                     idx   <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The read port only carries the cursor while a walk is in flight.
   assign raddr = ((state == READ) || (state == HOLD)) ? AW'(idx) : '0;

   assign ob.out_valid = valid_q;
   assign ob.out_idx   = idx;
   assign ob.out_data  = data_q;
   assign ob.out_last  = valid_q && (idx == LAST_IDX);

   assign busy  = busy_q;
   assign done  = done_q;
   assign dirty = dirty_q;
endmodule

// File: tb/tb_ysyx_25040118_regdump.sv
`timescale 1ns/1ps
// Bench for the register dump engine. A regfile lives in the bench; the
// stimulus process issues dumps and snoop writes, and the monitor predicts
// every beat from "beat j carries xj as it was in the cycle before it
// appears", and dirty from "a write at or after a register's capture cycle".
module tb_ysyx_25040118_regdump;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        wen = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        done;
   logic [15:0] dirty;

   ysyx_25040118_regdump_if #(.XLEN(32), .IW(4)) ob ();

   ysyx_25040118_regdump #(.NREGS(16), .XLEN(32), .AW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .raddr (raddr),
      .rdata (rdata),
      .wen   (wen),
      .waddr (waddr),
      .ob    (ob),
      .done  (done),
      .dirty (dirty)
   );

   always #5 clk = ~clk;

   // bench-side regfile: combinational read, write at posedge
   logic [31:0] rf [32];
   assign rdata = rf[raddr];
   always @(posedge clk) if (wen) rf[waddr] <= wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {int c; int a;} wr_t;

   int          q_idx[$];
   wr_t         wlog[$];
   int          cap[16];
   logic [31:0] snap[32];
   logic [31:0] beat_data[16];
   bit          m_active = 0;
   bit          m_open = 0;
   int          m_start = -10, m_next = -1, m_done = -1, m_cur = 0;
   logic [31:0] m_data = '0;
   logic [15:0] m_dirty = '0;
   int          done_seen = -1;

   // monitor / scoreboard: samples at negedge
   initial begin
      bit          was;
      logic [15:0] exp_d;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_active = 0; m_open = 0; m_next = -1; m_done = -1;
            q_idx.delete(); wlog.delete(); m_dirty = '0;
         end else begin
            was = m_active;
            if (!was) begin
               chk("idle_busy", busy, 0);
               chk("idle_valid", ob.out_valid, 0);
               chk("idle_done", done, 0);
               chk("idle_raddr", raddr, 0);
               chk("dirty_held", dirty, m_dirty);
            end else begin
               chk("busy", busy, 64'(cyc > m_start));
               if (m_next == cyc + 1 && q_idx.size() > 0)
                  chk("raddr", raddr, q_idx[0]);
               if (cyc == m_next) begin
                  if (q_idx.size() == 0) begin
                     errors++; checks++;
                     $display("FAIL scoreboard: beat with empty queue (cycle %0d)", cyc);
                     m_cur = 15;
                  end else m_cur = q_idx.pop_front();
                  m_data = (m_cur == 0) ? 32'h0 : snap[m_cur];
                  cap[m_cur] = cyc - 1;
                  m_open = 1; m_next = -1;
                  beat_data[m_cur] = ob.out_data;
                  chk("beat_valid", ob.out_valid, 1);
                  chk("beat_idx", ob.out_idx, m_cur);
                  chk("beat_data", ob.out_data, m_data);
               end else if (m_open) begin
                  chk("hold_valid", ob.out_valid, 1);
                  chk("hold_idx", ob.out_idx, m_cur);
                  chk("hold_data", ob.out_data, m_data);
               end else begin
                  chk("gap_valid", ob.out_valid, 0);
                  chk("gap_last", ob.out_last, 0);
               end
               if (m_open) chk("last", ob.out_last, 64'(m_cur == 15));
               if (cyc == m_done) begin
                  chk("done", done, 1);
                  exp_d = '0;
                  for (int j = 1; j < 16; j++)
                     foreach (wlog[k])
                        if (wlog[k].a == j && wlog[k].c >= cap[j]) exp_d[j] = 1'b1;
                  chk("dirty", dirty, exp_d);
                  m_dirty = exp_d;
                  m_active = 0;
               end else chk("no_done", done, 0);
               if (m_open && ob.out_ready) begin
                  m_open = 0;
                  if (m_cur == 15) m_done = cyc + 1;
                  else m_next = cyc + 2;
               end
               if (m_active && wen) wlog.push_back('{cyc, int'(waddr)});
            end
            if (done === 1'b1) done_seen = cyc;
            if (start && !was) begin
               m_active = 1; m_start = cyc; m_next = cyc + 2; m_done = -1;
               m_open = 0; wlog.delete();
            end
         end
         for (int i = 0; i < 32; i++) snap[i] = rf[i];
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic load_rf();
      for (int i = 0; i < 32; i++) begin
         wen = 1'b1; waddr = 5'(i);
         wdata = (i == 0) ? 32'hBAD : 32'h100 + 32'(i);
         step();
      end
      wen = 1'b0;
   endtask

   // mode: 0 ready high, 1 stall beat3, 2 x5/x1 writes, 3 x7 in READ + ignored
   //       writes, 4 start while busy, 5 random, 6 reset at beat7
   task automatic run_dump(input int mode, output int s0);
      int budget = 0, stall = 0, vis, rd;
      bit f_a = 0, f_b = 0, f_c = 0;
      for (int i = 0; i < 16; i++) q_idx.push_back(i);
      s0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      while (m_active && budget < 3000) begin
         vis = m_open ? m_cur : ((m_next == cyc && q_idx.size() > 0) ? q_idx[0] : -1);
         rd  = (m_next == cyc + 1 && q_idx.size() > 0) ? q_idx[0] : -1;
         wen = 1'b0; start = 1'b0; ob.out_ready = 1'b1;
         case (mode)
            1: if (vis == 3 && stall < 5) begin ob.out_ready = 1'b0; stall++; end
            2: begin
               if (vis == 2 && !f_a) begin wen = 1; waddr = 5; wdata = 32'hDEAD; f_a = 1; end
               else if (vis == 3 && !f_b) begin wen = 1; waddr = 1; wdata = 32'h55; f_b = 1; end
            end
            3: begin
               if (rd == 7) begin wen = 1; waddr = 7; wdata = 32'h777; end
               else if (vis == 2 && !f_a) begin wen = 1; waddr = 0; wdata = 32'h999; f_a = 1; end
               else if (vis == 4 && !f_b) begin wen = 1; waddr = 20; wdata = 32'h1234; f_b = 1; end
            end
            4: if ((vis == 5 && !f_a) || (rd == 10 && !f_b)) begin
               start = 1'b1;
               if (vis == 5) f_a = 1; else f_b = 1;
            end
            5: begin
               ob.out_ready = ($urandom_range(0, 99) < 60);
               if ($urandom_range(0, 2) == 0) begin
                  wen = 1; waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
               end
               if ($urandom_range(0, 19) == 0) start = 1'b1;
            end
            6: begin
               if (vis == 3 && !f_a) begin wen = 1; waddr = 1; wdata = 32'h11; f_a = 1; end
               if (vis == 7 && !f_c) begin
                  f_c = 1; wen = 1'b0;
                  rst = 1'b1;
                  #1;
                  chk("rst_valid", ob.out_valid, 0);
                  chk("rst_busy", busy, 0);
                  chk("rst_raddr", raddr, 0);
                  chk("rst_idx", ob.out_idx, 0);
                  chk("rst_data", ob.out_data, 0);
                  chk("rst_last", ob.out_last, 0);
                  chk("rst_done", done, 0);
                  chk("rst_dirty", dirty, 0);
                  step();
                  rst = 1'b0;
                  break;
               end
            end
            default: ;
         endcase
         step();
         budget++;
      end
      wen = 1'b0; start = 1'b0; ob.out_ready = 1'b1;
      if (budget >= 3000) begin
         checks++; errors++;
         $display("FAIL timeout: dump mode %0d still active after %0d cycles", mode, budget);
      end
      step();
   endtask

   initial begin
      int s0;
      ob.out_ready = 1'b1;
      #1;
      chk("reset_valid", ob.out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dirty", dirty, 0);
      chk("reset_idx", ob.out_idx, 0);
      step();
      load_rf();
      rst = 1'b0;
      step();

      run_dump(0, s0);
      chk("t1_done_latency", done_seen - s0, 33);
      chk("t1_dirty", dirty, 16'h0000);
      chk("t1_beat0_zero", beat_data[0], 0);
      chk("t1_beat15", beat_data[15], 32'h10F);

      run_dump(1, s0);
      chk("t2_beat4", beat_data[4], 32'h104);

      run_dump(2, s0);
      chk("t3_beat5", beat_data[5], 32'hDEAD);
      chk("t3_dirty", dirty, 16'h0002);

      run_dump(3, s0);
      chk("t4_beat7_old", beat_data[7], 32'h107);
      chk("t4_dirty", dirty, 16'h0080);

      run_dump(4, s0);
      chk("t5_single_dump", done_seen - s0, 33);

      run_dump(6, s0);
      run_dump(0, s0);
      chk("t6_restart_latency", done_seen - s0, 33);

      for (int r = 0; r < 5; r++) run_dump(5, s0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
